// File: rtl/mb_out_pkg.sv
// mb_out_pkg
//   Shared definitions for the macroblock output arbiter slice.
//   - IDLE_ENC / BUSY_ENC : one-hot state encodings, wrapped by state_e
//   - BURST_LEN_DEF       : default beats per macroblock burst
//   - BEAT_*              : beat index of each field inside a burst
//   - beat_max()          : last beat index for a given burst length
package mb_out_pkg;

  localparam int BURST_LEN_DEF = 7;

  localparam logic [1:0] IDLE_ENC = 2'b01;
  localparam logic [1:0] BUSY_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    BUSY = BUSY_ENC
  } state_e;

  localparam logic [2:0] BEAT_AC0  = 3'd0;
  localparam logic [2:0] BEAT_AC1  = 3'd1;
  localparam logic [2:0] BEAT_AC2  = 3'd2;
  localparam logic [2:0] BEAT_AC3  = 3'd3;
  localparam logic [2:0] BEAT_UV0  = 3'd4;
  localparam logic [2:0] BEAT_UV1  = 3'd5;
  localparam logic [2:0] BEAT_INFO = 3'd6;

  function automatic logic [2:0] beat_max(input int burst_len);
    return 3'(burst_len - 1);
  endfunction

endpackage

// File: rtl/mb_out_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search: returns the first set bit of req_i
//   found by scanning upward from ptr_i and wrapping modulo N.
//   Ports:
//     req_i  [N]  request vector
//     ptr_i  [IW] search start index
//     idx_o  [IW] index of the selected requester (0 when none)
//     any_o       at least one request is set
module rr_pick #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Scan from the farthest offset back to the nearest so the requester
  // closest to ptr_i is the one left in idx_o.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (req_i[j]) begin
        idx_o = IW'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mb_out_arbiter.sv
// mb_out_arbiter
//   Round-robin arbiter sharing one encoded-macroblock output FIFO between
//   NUM_SRC encoder cores. The grant is locked for a whole burst so beats of
//   different cores never interleave; FIFO backpressure is honoured and the
//   burst framing is checked.
//   Optional feature macro: MB_OUT_STALL_CNT_EN adds stall_cnt_o.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     src_valid_i    per-core beat valid
//     src_last_i     per-core last-beat flag
//     src_data_i     per-core beat data, core i at [i*DATA_W +: DATA_W]
//     src_ready_o    per-core beat accepted (combinational)
//     fifo_full_i    FIFO programmable-full
//     fifo_wr_o      FIFO write strobe (registered)
//     data_out_o     FIFO write data (registered)
//     burst_done_o   pulse with the write of a burst's last beat
//     burst_src_o    core whose burst completed, valid with burst_done_o
//     mb_count_o     completed bursts, wrapping
//     frame_err_o    sticky burst framing error
//     stall_cnt_o    saturating count of backpressured cycles (optional)
module mb_out_arbiter
  import mb_out_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 1024,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  input  logic [NUM_SRC-1:0]        src_last_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_wr_o,
  output logic [DATA_W-1:0]         data_out_o,
  output logic                      burst_done_o,
  output logic [2:0]                burst_src_o,
  output logic [31:0]               mb_count_o,
  output logic                      frame_err_o
`ifdef MB_OUT_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam int IW = $clog2(NUM_SRC);
  localparam logic [2:0]    LAST_BEAT = beat_max(BURST_LEN);
  localparam logic [IW-1:0] LAST_SRC  = IW'(NUM_SRC - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]          beat_cnt_q, beat_cnt_d;
  logic                fifo_wr_q, fifo_wr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                burst_done_q, burst_done_d;
  logic [2:0]          burst_src_q, burst_src_d;
  logic [31:0]         mb_count_q, mb_count_d;
  logic                frame_err_q, frame_err_d;
`ifdef MB_OUT_STALL_CNT_EN
  logic [31:0]         stall_cnt_q, stall_cnt_d;
`endif

  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                cur_valid;
  logic                cur_last;
  logic [DATA_W-1:0]   cur_data;
  logic                busy;
  logic                xfer;
  logic                at_last_beat;
  logic                end_burst;

  rr_pick #(
    .N(NUM_SRC)
  ) u_rr_pick (
    .req_i (src_valid_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IW'(i)) begin
        cur_data = src_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cur_valid    = src_valid_i[grant_q];
  assign cur_last     = src_last_i[grant_q];
  assign busy         = (state_q == BUSY);
  assign xfer         = busy && cur_valid && !fifo_full_i;
  assign at_last_beat = (beat_cnt_q == LAST_BEAT);
  // A missing last flag on the final beat still closes the burst, so a
  // misbehaving core cannot hold the FIFO forever.
  assign end_burst    = xfer && (cur_last || at_last_beat);

  always_comb begin
    src_ready_o = '0;
    if (busy && !fifo_full_i) begin
      src_ready_o[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    fifo_wr_d    = xfer;
    data_out_d   = xfer ? cur_data : data_out_q;
    burst_done_d = end_burst;
    burst_src_d  = end_burst ? 3'(grant_q) : burst_src_q;
    mb_count_d   = mb_count_q + 32'(end_burst);
    // Early last and missing last both reduce to the flag disagreeing with
    // the beat position.
    frame_err_d  = frame_err_q | (xfer && (cur_last != at_last_beat));
`ifdef MB_OUT_STALL_CNT_EN
    stall_cnt_d  = stall_cnt_q;
    if (busy && cur_valid && fifo_full_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (end_burst) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      fifo_wr_q    <= 1'b0;
      data_out_q   <= '0;
      burst_done_q <= 1'b0;
      burst_src_q  <= '0;
      mb_count_q   <= '0;
      frame_err_q  <= 1'b0;
`ifdef MB_OUT_STALL_CNT_EN
      stall_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      fifo_wr_q    <= fifo_wr_d;
      data_out_q   <= data_out_d;
      burst_done_q <= burst_done_d;
      burst_src_q  <= burst_src_d;
      mb_count_q   <= mb_count_d;
      frame_err_q  <= frame_err_d;
`ifdef MB_OUT_STALL_CNT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign fifo_wr_o    = fifo_wr_q;
  assign data_out_o   = data_out_q;
  assign burst_done_o = burst_done_q;
  assign burst_src_o  = burst_src_q;
  assign mb_count_o   = mb_count_q;
  assign frame_err_o  = frame_err_q;
`ifdef MB_OUT_STALL_CNT_EN
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mb_out_arbiter.sv
// tb_mb_out_arbiter
//   Directed bench for mb_out_arbiter with four encoder cores. Each core is
//   a small behavioural source that walks its bursts beat by beat; every
//   beat carries a word tagging core, burst number and beat index, and the
//   tests list the exact write order they expect.
//   Optional feature macro: MB_OUT_STALL_CNT_EN (checks stall_cnt_o).
module tb_mb_out_arbiter;
  import mb_out_pkg::*;

  localparam int NSRC  = 4;
  localparam int DW    = 1024;
  localparam int BLEN  = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NSRC-1:0]   src_valid = '0;
  logic [NSRC-1:0]   src_last = '0;
  logic [NSRC*DW-1:0] src_data = '0;
  logic [NSRC-1:0]   src_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr;
  logic [DW-1:0]     data_out;
  logic              burst_done;
  logic [2:0]        burst_src;
  logic [31:0]       mb_count;
  logic              frame_err;
`ifdef MB_OUT_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  mb_out_arbiter #(
    .NUM_SRC  (NSRC),
    .DATA_W   (DW),
    .BURST_LEN(BLEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_valid_i  (src_valid),
    .src_last_i   (src_last),
    .src_data_i   (src_data),
    .src_ready_o  (src_ready),
    .fifo_full_i  (fifo_full),
    .fifo_wr_o    (fifo_wr),
    .data_out_o   (data_out),
    .burst_done_o (burst_done),
    .burst_src_o  (burst_src),
    .mb_count_o   (mb_count),
    .frame_err_o  (frame_err)
`ifdef MB_OUT_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cycle;
  int pend[NSRC];
  int beat[NSRC];
  int lastBeat[NSRC];
  int burstNo[NSRC];
  logic [NSRC-1:0] hs;
  logic [31:0] expQ[$];
  int expSrcQ[$];
  int wrCount, doneCount, firstWr, lastWr;
  int fullTrigCore, fullTrigBeat, fullLen, fullLeft, fullChecks;

  function automatic logic [31:0] mkWord(input int c, input int b, input int k);
    return {8'hA5, 8'(c), 8'(b), 8'(k)};
  endfunction

  task automatic pushBurst(input int c, input int b, input int n);
    for (int k = 0; k < n; k++) expQ.push_back(mkWord(c, b, k));
    expSrcQ.push_back(c);
  endtask

  // One clock: observe the previous edge, advance the cores, drive the next
  // beat and note which handshakes will happen at the coming edge.
  task automatic step();
    logic [31:0] w;
    int s;
    @(negedge clk);
    cycle++;
    if (fifo_wr) begin
      wrCount++;
      if (firstWr < 0) firstWr = cycle;
      lastWr = cycle;
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL write_order: got unexpected write %h, expected no write", data_out[31:0]);
      end else begin
        w = expQ.pop_front();
        if (data_out !== {32{w}}) begin
          bad++;
          $display("[TB] FAIL write_data: got %h, expected %h", data_out[31:0], w);
        end
      end
    end
    if (burst_done) begin
      doneCount++;
      total++;
      if (expSrcQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL burst_done: got unexpected pulse src=%0d, expected none", burst_src);
      end else begin
        s = expSrcQ.pop_front();
        if (burst_src !== 3'(s)) begin
          bad++;
          $display("[TB] FAIL burst_src: got %0d, expected %0d", burst_src, s);
        end
      end
      total++;
      if (mb_count !== 32'(doneCount)) begin
        bad++;
        $display("[TB] FAIL mb_count_at_done: got %0d, expected %0d", mb_count, doneCount);
      end
      total++;
      if (fifo_wr !== 1'b1) begin
        bad++;
        $display("[TB] FAIL done_with_write: got fifo_wr=%b, expected 1", fifo_wr);
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (hs[i]) begin
        if (beat[i] == lastBeat[i]) begin
          pend[i]--;
          beat[i] = 0;
          burstNo[i]++;
          lastBeat[i] = int'(BEAT_INFO);
        end else begin
          beat[i]++;
        end
      end
    end
    if (fullLen > 0 && pend[fullTrigCore] > 0 && beat[fullTrigCore] == fullTrigBeat) begin
      fullLeft = fullLen;
      fullLen = 0;
    end
    fifo_full = (fullLeft > 0);
    for (int i = 0; i < NSRC; i++) begin
      src_valid[i] = (pend[i] > 0);
      src_last[i]  = (pend[i] > 0) && (beat[i] == lastBeat[i]);
      src_data[i*DW +: DW] = {32{mkWord(i, burstNo[i], beat[i])}};
    end
    #1;
    hs = src_valid & src_ready;
    if (fullLeft > 0) begin
      fullChecks++;
      total++;
      if (src_ready !== '0) begin
        bad++;
        $display("[TB] FAIL ready_while_full: got %b, expected 0000", src_ready);
      end
      fullLeft--;
    end
  endtask

  task automatic runUntilDone(input int maxCyc, input string name);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < maxCyc) begin
      step();
      n++;
      busy = (expQ.size() != 0);
      for (int i = 0; i < NSRC; i++) if (pend[i] > 0) busy = 1'b1;
    end
    total++;
    if (busy) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got still busy after %0d cycles, expected done", name, n);
    end
    repeat (3) step();
  endtask

  task automatic stepUntilBeat(input int c, input int b, input int maxCyc, input string name);
    int n = 0;
    while (beat[c] != b && n < maxCyc) begin
      step();
      n++;
    end
    total++;
    if (beat[c] != b) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got beat %0d, expected beat %0d", name, beat[c], b);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      pend[i] = 0;
      beat[i] = 0;
      burstNo[i] = 0;
      lastBeat[i] = int'(BEAT_INFO);
    end
    hs = '0;
    src_valid = '0;
    src_last = '0;
    src_data = '0;
    fifo_full = 1'b0;
    expQ.delete();
    expSrcQ.delete();
    wrCount = 0;
    doneCount = 0;
    firstWr = -1;
    lastWr = -1;
    fullTrigCore = 0;
    fullTrigBeat = 0;
    fullLen = 0;
    fullLeft = 0;
    fullChecks = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle = 0;
  endtask

  task automatic test_reset();
    doReset();
    step();
    total++;
    if (fifo_wr !== 1'b0) begin bad++; $display("[TB] FAIL reset_fifo_wr: got %b, expected 0", fifo_wr); end
    total++;
    if (data_out !== '0) begin bad++; $display("[TB] FAIL reset_data_out: got %h, expected 0", data_out[31:0]); end
    total++;
    if (burst_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_burst_done: got %b, expected 0", burst_done); end
    total++;
    if (burst_src !== 3'd0) begin bad++; $display("[TB] FAIL reset_burst_src: got %0d, expected 0", burst_src); end
    total++;
    if (mb_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_mb_count: got %0d, expected 0", mb_count); end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err: got %b, expected 0", frame_err); end
    total++;
    if (src_ready !== '0) begin bad++; $display("[TB] FAIL reset_src_ready: got %b, expected 0000", src_ready); end
`ifdef MB_OUT_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt); end
`endif
  endtask

  task automatic test_single_burst();
    int firstValid;
    doReset();
    pend[0] = 1;
    pushBurst(0, 0, 7);
    firstValid = cycle + 1;
    runUntilDone(40, "single");
    total++;
    if (wrCount != 7) begin bad++; $display("[TB] FAIL single_writes: got %0d, expected 7", wrCount); end
    total++;
    if (firstWr != firstValid + 2) begin bad++; $display("[TB] FAIL single_latency: got cycle %0d, expected cycle %0d", firstWr, firstValid + 2); end
    total++;
    if (lastWr - firstWr + 1 != 7) begin bad++; $display("[TB] FAIL single_span: got %0d, expected 7", lastWr - firstWr + 1); end
    total++;
    if (mb_count !== 32'd1) begin bad++; $display("[TB] FAIL single_mb_count: got %0d, expected 1", mb_count); end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL single_frame_err: got %b, expected 0", frame_err); end
  endtask

  task automatic test_round_robin();
    doReset();
    pend[0] = 3;
    pend[1] = 3;
    pushBurst(0, 0, 7);
    pushBurst(1, 0, 7);
    pushBurst(0, 1, 7);
    pushBurst(1, 1, 7);
    pushBurst(0, 2, 7);
    pushBurst(1, 2, 7);
    runUntilDone(200, "rr");
    total++;
    if (wrCount != 42) begin bad++; $display("[TB] FAIL rr_writes: got %0d, expected 42", wrCount); end
    total++;
    if (lastWr - firstWr + 1 != 47) begin bad++; $display("[TB] FAIL rr_span: got %0d, expected 47", lastWr - firstWr + 1); end
    total++;
    if (mb_count !== 32'd6) begin bad++; $display("[TB] FAIL rr_mb_count: got %0d, expected 6", mb_count); end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL rr_frame_err: got %b, expected 0", frame_err); end
  endtask

  task automatic test_backpressure();
    doReset();
    pend[1] = 1;
    fullTrigCore = 1;
    fullTrigBeat = 3;
    fullLen = 5;
    pushBurst(1, 0, 7);
    runUntilDone(60, "stall");
    total++;
    if (fullChecks != 5) begin bad++; $display("[TB] FAIL stall_cycles: got %0d, expected 5", fullChecks); end
    total++;
    if (wrCount != 7) begin bad++; $display("[TB] FAIL stall_writes: got %0d, expected 7", wrCount); end
    total++;
    if (mb_count !== 32'd1) begin bad++; $display("[TB] FAIL stall_mb_count: got %0d, expected 1", mb_count); end
`ifdef MB_OUT_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd5) begin bad++; $display("[TB] FAIL stall_cnt: got %0d, expected 5", stall_cnt); end
`endif
  endtask

  task automatic test_frame_err();
    doReset();
    pend[0] = 1;
    lastBeat[0] = 4;
    pend[1] = 1;
    pushBurst(0, 0, 5);
    pushBurst(1, 0, 7);
    runUntilDone(60, "frame");
    total++;
    if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL frame_err: got %b, expected 1", frame_err); end
    total++;
    if (wrCount != 12) begin bad++; $display("[TB] FAIL frame_writes: got %0d, expected 12", wrCount); end
    total++;
    if (mb_count !== 32'd2) begin bad++; $display("[TB] FAIL frame_mb_count: got %0d, expected 2", mb_count); end
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    pend[0] = 1;
    pushBurst(0, 0, 7);
    stepUntilBeat(0, 2, 20, "midrst");
    total++;
    if (fifo_wr !== 1'b1) begin bad++; $display("[TB] FAIL midrst_active: got fifo_wr=%b, expected 1", fifo_wr); end
    rst_n = 1'b0;
    #1;
    total++;
    if (fifo_wr !== 1'b0) begin bad++; $display("[TB] FAIL midrst_fifo_wr: got %b, expected 0", fifo_wr); end
    total++;
    if (src_ready !== '0) begin bad++; $display("[TB] FAIL midrst_src_ready: got %b, expected 0000", src_ready); end
    doReset();
    pend[1] = 1;
    pushBurst(1, 0, 7);
    runUntilDone(40, "postrst");
    total++;
    if (mb_count !== 32'd1) begin bad++; $display("[TB] FAIL postrst_mb_count: got %0d, expected 1", mb_count); end
    total++;
    if (wrCount != 7) begin bad++; $display("[TB] FAIL postrst_writes: got %0d, expected 7", wrCount); end
  endtask

  task automatic test_late_requester();
    doReset();
    pend[3] = 2;
    pushBurst(3, 0, 7);
    pushBurst(1, 0, 7);
    pushBurst(3, 1, 7);
    stepUntilBeat(3, 2, 20, "late");
    pend[1] = 1;
    runUntilDone(80, "late");
    total++;
    if (mb_count !== 32'd3) begin bad++; $display("[TB] FAIL late_mb_count: got %0d, expected 3", mb_count); end
    total++;
    if (wrCount != 21) begin bad++; $display("[TB] FAIL late_writes: got %0d, expected 21", wrCount); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_frame_err();
    test_reset_mid_burst();
    test_late_requester();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
